// File: rtl/fb_pkg.sv
// Shared definitions for the single-frame buffer controller.
//  H_PIX / V_PIX : default frame geometry (pixels per line / lines per frame)
//  SIZE          : pixels per frame
//  AW            : RAM address width
//  fb_state_t    : controller state (IDLE, FILL, DRAIN)
package fb_pkg;

  localparam int H_PIX = 960;
  localparam int V_PIX = 540;
  localparam int SIZE  = H_PIX * V_PIX;
  localparam int AW    = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_rd_stage.sv
// Read side of the frame buffer: walks the RAM in raster order and presents
// each pixel through a registered valid/ready output stage.
// Ports:
//  clk, rst_n    clock, synchronous active-low reset
//  en_i          high while the controller is draining; low clears the walk
//  out_ready_i   downstream ready
//  ram_dout_i    RAM read data (combinational from ram_ra_o)
//  out_valid_o   output pixel valid
//  out_data_o    output pixel
//  out_sof_o     pixel 0 of the frame
//  out_eol_o     last pixel of a line
//  ram_ra_o      RAM read address
//  last_hs_o     the final pixel of the frame is being handed off this cycle
// Handshake: a beat transfers on a rising clk edge where out_valid_o && out_ready_i;
// while out_valid_o && !out_ready_i the data/sof/eol outputs hold steady.
module fb_rd_stage #(
  parameter int H_PIX = 8,
  parameter int SIZE  = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          out_ready_i,
  input  logic [7:0]    ram_dout_i,
  output logic          out_valid_o,
  output logic [7:0]    out_data_o,
  output logic          out_sof_o,
  output logic          out_eol_o,
  output logic [AW-1:0] ram_ra_o,
  output logic          last_hs_o
);

  localparam int CW = (H_PIX > 1) ? $clog2(H_PIX) : 1;

  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          last_q, last_d;
  logic          all_loaded_q, all_loaded_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] col_q, col_d;
  logic          load;

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    sof_d        = sof_q;
    eol_d        = eol_q;
    last_d       = last_q;
    all_loaded_d = all_loaded_q;
    rd_addr_d    = rd_addr_q;
    col_d        = col_q;
    // Stage refills when empty or when its current pixel leaves this cycle;
    // all_loaded stops it after the last address so nothing is read twice.
    load = en_i && (!valid_q || out_ready_i) && !all_loaded_q;
    if (!en_i) begin
      valid_d      = 1'b0;
      last_d       = 1'b0;
      all_loaded_d = 1'b0;
      rd_addr_d    = '0;
      col_d        = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = ram_dout_i;
      sof_d   = (rd_addr_q == '0);
      eol_d   = (col_q == CW'(H_PIX - 1));
      last_d  = (rd_addr_q == AW'(SIZE - 1));
      col_d   = (col_q == CW'(H_PIX - 1)) ? '0 : col_q + CW'(1);
      if (rd_addr_q == AW'(SIZE - 1)) begin
        rd_addr_d    = '0;
        all_loaded_d = 1'b1;
      end else begin
        rd_addr_d = rd_addr_q + AW'(1);
      end
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      last_q       <= 1'b0;
      all_loaded_q <= 1'b0;
      rd_addr_q    <= '0;
      col_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      last_q       <= last_d;
      all_loaded_q <= all_loaded_d;
      rd_addr_q    <= rd_addr_d;
      col_q        <= col_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_sof_o   = sof_q;
  assign out_eol_o   = eol_q;
  assign ram_ra_o    = rd_addr_q;
  assign last_hs_o   = en_i && valid_q && out_ready_i && last_q;

endmodule

// File: rtl/frame_buf_ctrl.sv
// Single-bank frame buffer sequencer: fills the pixel RAM from the capture
// stream starting at an in_sof beat, then drains the whole frame in raster
// order. Fill and drain never overlap.
// Ports:
//  clk, rst_n                    clock, synchronous active-low reset
//  in_valid/in_ready/in_data/in_sof   capture-side pixel stream
//  out_valid/out_ready/out_data/out_sof/out_eol   pipeline-side pixel stream
//  ram_wa/ram_din/ram_write      RAM write port
//  ram_ra/ram_dout               RAM async read port
//  busy                          controller is in FILL or DRAIN
//  resync_cnt                    saturating count of frames restarted by an early in_sof
// Handshake: both streams transfer on a rising clk edge where valid && ready.
module frame_buf_ctrl #(
  parameter  int H_PIX = fb_pkg::H_PIX,
  parameter  int V_PIX = fb_pkg::V_PIX,
  localparam int SIZE  = H_PIX * V_PIX,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_sof,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_sof,
  output logic          out_eol,
  output logic [AW-1:0] ram_wa,
  output logic [7:0]    ram_din,
  output logic          ram_write,
  output logic [AW-1:0] ram_ra,
  input  logic [7:0]    ram_dout,
  output logic          busy,
  output logic [7:0]    resync_cnt
);

  import fb_pkg::*;

  fb_state_t     state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    resync_q, resync_d;
  logic          accept;
  logic          last_hs;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    resync_d  = resync_q;
    unique case (state_q)
      IDLE: begin
        // Beats before the first in_sof are dropped.
        if (accept && in_sof) begin
          wr_addr_d = AW'(1);
          state_d   = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          if (in_sof) begin
            wr_addr_d = AW'(1);
            if (resync_q != 8'hFF) resync_d = resync_q + 8'd1;
          end else if (wr_addr_q == AW'(SIZE - 1)) begin
            wr_addr_d = '0;
            state_d   = DRAIN;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      resync_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      resync_q  <= resync_d;
    end
  end

  assign in_ready   = (state_q != DRAIN);
  assign ram_write  = rst_n && accept && ((state_q == FILL) || in_sof);
  assign ram_din    = in_data;
  assign ram_wa     = in_sof ? '0 : wr_addr_q;
  assign busy       = (state_q != IDLE);
  assign resync_cnt = resync_q;

  fb_rd_stage #(
    .H_PIX (H_PIX),
    .SIZE  (SIZE),
    .AW    (AW)
  ) u_rd_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q == DRAIN),
    .out_ready_i (out_ready),
    .ram_dout_i  (ram_dout),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_sof_o   (out_sof),
    .out_eol_o   (out_eol),
    .ram_ra_o    (ram_ra),
    .last_hs_o   (last_hs)
  );

endmodule

// File: tb/tb_frame_buf_ctrl.sv
module tb_frame_buf_ctrl;

  localparam int H = 8;
  localparam int V = 4;
  localparam int N = H * V;
  localparam int AWT = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     in_data = '0;
  logic           in_sof = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [7:0]     out_data;
  logic           out_sof;
  logic           out_eol;
  logic [AWT-1:0] ram_wa;
  logic [7:0]     ram_din;
  logic           ram_write;
  logic [AWT-1:0] ram_ra;
  logic [7:0]     ram_dout;
  logic           busy;
  logic [7:0]     resync_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // clock / reset block
  always #5 clk = ~clk;

  // RAM model: registered write, async read
  logic [7:0] mem [0:N-1];
  always @(posedge clk) if (ram_write) mem[ram_wa] <= ram_din;
  assign ram_dout = mem[ram_ra];

  frame_buf_ctrl #(.H_PIX(H), .V_PIX(V)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol),
    .ram_wa(ram_wa), .ram_din(ram_din), .ram_write(ram_write),
    .ram_ra(ram_ra), .ram_dout(ram_dout),
    .busy(busy), .resync_cnt(resync_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input beat; checks the write strobe and address just before the edge.
  task automatic send_beat(input logic [7:0] d, input logic sof, input logic exp_wr,
                           input logic [AWT-1:0] exp_wa);
    in_valid = 1'b1; in_data = d; in_sof = sof;
    #1;
    tests_run++;
    if (ram_write !== exp_wr || (exp_wr && ram_wa !== exp_wa)) begin
      tests_failed++;
      $display("FAIL beat_write d=%0d: ram_write=%b ram_wa=%0d, expected %b / %0d",
               d, ram_write, ram_wa, exp_wr, exp_wa);
    end
    tick();
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // junk beats, then sof + N-1 beats of base..base+N-1; ends in DRAIN
  task automatic fill_frame(input logic [7:0] base, input int junk);
    for (int j = 0; j < junk; j++) send_beat(8'hEE, 1'b0, 1'b0, '0);
    send_beat(base, 1'b1, 1'b1, '0);
    for (int k = 1; k < N; k++) send_beat(base + 8'(k), 1'b0, 1'b1, AWT'(k));
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_entry: busy=%b in_ready=%b, expected 1 / 0", busy, in_ready);
    end
    for (int k = 0; k < N; k++) begin
      tests_run++;
      if (mem[k] !== base + 8'(k)) begin
        tests_failed++;
        $display("FAIL ram_content[%0d]: got %0d, expected %0d", k, mem[k], base + 8'(k));
      end
    end
  endtask

  // Drain a full frame; bp=1 randomises out_ready, bp=0 demands 1 pixel/clk.
  task automatic drain_frame(input logic [7:0] base, input logic bp);
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] held = '0;
    logic r;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_first_cycle: out_valid=%b, expected 0", out_valid);
    end
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    while (got < N && cyc < 400) begin
      cyc++;
      if (stalled) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          tests_failed++;
          $display("FAIL stall_hold: valid=%b data=%0d, expected 1 / %0d", out_valid, out_data, held);
        end
      end
      if (out_valid === 1'b1) begin
        tests_run++;
        if (out_data !== base + 8'(got) || out_sof !== (got == 0) || out_eol !== ((got % H) == H - 1)) begin
          tests_failed++;
          $display("FAIL drain_beat[%0d]: data=%0d sof=%b eol=%b, expected %0d / %b / %b",
                   got, out_data, out_sof, out_eol, base + 8'(got), got == 0, (got % H) == H - 1);
        end
      end else if (!bp) begin
        tests_run++;
        tests_failed++;
        $display("FAIL drain_bubble[%0d]: out_valid=0, expected 1", got);
      end
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      stalled = out_valid && !r;
      held = out_data;
      if (out_valid === 1'b1 && r) got++;
      tick();
    end
    tests_run++;
    if (got != N) begin
      tests_failed++;
      $display("FAIL drain_count: got %0d beats, expected %0d", got, N);
    end
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_exit: valid=%b busy=%b in_ready=%b, expected 0 / 0 / 1",
               out_valid, busy, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b1; in_data = 8'h55;
    tick(); tick();
    tests_run++;
    if (in_ready !== 1'b1 || ram_write !== 1'b0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || resync_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b ram_write=%b out_valid=%b busy=%b resync=%0d, expected 1 0 0 0 0",
               in_ready, ram_write, out_valid, busy, resync_cnt);
    end
    in_valid = 1'b0; in_sof = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_and_drain();
    fill_frame(8'd0, 5);
    drain_frame(8'd0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_frame(8'd40, 0);
    drain_frame(8'd40, 1'b1);
  endtask

  task automatic test_early_sof();
    send_beat(8'd50, 1'b1, 1'b1, '0);
    for (int k = 1; k <= 10; k++) send_beat(8'd50 + 8'(k), 1'b0, 1'b1, AWT'(k));
    tests_run++;
    if (resync_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL resync_before: resync_cnt=%0d, expected 0", resync_cnt);
    end
    fill_frame(8'd100, 0);
    tests_run++;
    if (resync_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL resync_after: resync_cnt=%0d, expected 1", resync_cnt);
    end
    drain_frame(8'd100, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    fill_frame(8'd200, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || resync_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_drain_reset: valid=%b busy=%b in_ready=%b resync=%0d, expected 0 0 1 0",
               out_valid, busy, in_ready, resync_cnt);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    tick();
    fill_frame(8'd7, 2);
    drain_frame(8'd7, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) mem[k] = 8'hFF;
    test_reset();
    test_fill_and_drain();
    test_backpressure();
    test_early_sof();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
